mm_rr_arbiter: RTL and testbench
================================

// Module: mm_rr_arbiter
// PURPOSE
// Shares one MemoryMapped slave between NPORTS MemoryMapped masters, single clock domain.
// Round-robin arbitration with registered grant and optional burst hold.
// Sits in front of a register file or an mm_hs_synchronizer slave port.
// Accepted-transaction semantics are unchanged: a request completes in the cycle its busy is low.
// PARAMETERS
// NPORTS    4  number of requesters, >=2
// AWIDTH    8  address width
// DWIDTH    8  data width
// MAXBURST  1  back-to-back transactions a grantee may complete before yielding under contention, >=1
// PORTS
// reset    in   1                 asynchronous reset, active high
// clk      in   1                 clock
// s_addr   in   [NPORTS][AWIDTH]  per-requester address
// s_wreq   in   [NPORTS]          per-requester write request
// s_wdat   in   [NPORTS][DWIDTH]  per-requester write data
// s_rreq   in   [NPORTS]          per-requester read request
// s_rdat   out  [NPORTS][DWIDTH]  read data; every entry equals m_rdat
// s_busy   out  [NPORTS]          per-requester busy
// m_addr   out  AWIDTH            shared slave address
// m_wreq   out  1                 shared slave write request
// m_wdat   out  DWIDTH            shared slave write data
// m_rreq   out  1                 shared slave read request
// m_rdat   in   DWIDTH            shared slave read data, valid when accepted
// m_busy   in   1                 shared slave busy
// gnt_idx  out  clog2(NPORTS)     current grant index; informational, valid in GRANT
// BEHAVIOUR
// - req[i] = s_wreq[i] | s_rreq[i]. A requester holds its request and operands until its busy is low.
// - States (registered): IDLE, GRANT. Registers: state, gnt_idx, last_idx, burst cnt.
// - IDLE:
//   - All s_busy=1; m_wreq=m_rreq=0; m_addr=m_wdat=0.
//   - If |req: next GRANT; gnt_idx = first requester scanning last_idx+1, +2, ... cyclically; cnt=0.
// - GRANT (g=gnt_idx):
//   - m_addr/m_wdat/m_wreq/m_rreq = port g operands, combinational mux.
//   - s_busy[g]=m_busy; all other s_busy=1.
// - Completion = req[g] & ~m_busy; cnt increments and saturates at MAXBURST.
// - On completion, if any other req is active and cnt+1>=MAXBURST: next IDLE, last_idx=g.
// - Otherwise stay in GRANT: g keeps the slave, and back-to-back transactions from g take no idle cycle.
// - If ~req[g] in GRANT, either no further request or an abort before acceptance: next IDLE, last_idx=g.
//   An aborted transaction leaves no side effect at arbiter level.
// - Latency: request seen in IDLE at cycle t -> m_*req at t+1; earliest s_busy=0 at t+1.
// - Re-arbitration costs exactly one IDLE cycle between different grantees.
// - Simultaneous s_wreq & s_rreq from one port: forwarded unchanged (protocol violation, not filtered).
// - Non-granted requests never reach m_*; their s_busy stays 1 for the entire wait.
// - Fairness: with all ports requesting, grants rotate 0,1,...,NPORTS-1,0.
//   Worst-case wait is (NPORTS-1)*(MAXBURST transactions + 1 cycle).
// - Reset (any time, including mid-transaction):
//   - state=IDLE, last_idx=NPORTS-1 so port 0 wins first, cnt=0, gnt_idx=0.
//   - m_wreq=m_rreq=0, m_addr=m_wdat=0, all s_busy=1, all outputs immediately.
// - m_busy is ignored in IDLE.
// STRUCTURE
// - Package mm_arb_pkg: typedef enum logic {IDLE, GRANT} arb_state_t; IWIDTH=$clog2(NPORTS) helper function.
// - Sub-module rr_pick: combinational rotating-priority picker.
//   - Inputs: req vector and last_idx. Outputs: index and found flag.
// - Top: state/burst register, output mux, busy decode.
// TESTING
// 1. Reset; port1 wreq addr 0x12 wdat 0xA5, m_busy=0 -> next cycle m_wreq=1, m_addr=0x12, m_wdat=0xA5,
//    gnt_idx=1, s_busy[1]=0; then IDLE.
// 2. All 4 ports request continuously, MAXBURST=1, m_busy=0 -> completions from 0,1,2,3,0,... with one IDLE
//    cycle between each.
// 3. MAXBURST=4: port2 streams reads alone for 3 transactions (no idle), then port0 requests -> port2 completes
//    its 4th read, then IDLE, then port0 granted.
// 4. Port3 rreq, m_busy=1 for 5 cycles then 0 with m_rdat=0x3C -> s_busy[3]=1 for 5 GRANT cycles, 0 on the 6th
//    with s_rdat[3]=0x3C; other s_busy stay 1 throughout.
// 5. Assert reset while GRANT with m_wreq=1 -> m_wreq=0 and all s_busy=1 in the same cycle; after release, with
//    ports 0 and 2 requesting, port 0 is granted.
// 6. Granted port drops s_wreq while m_busy=1 -> next cycle state IDLE, m_wreq=0, the next requester in rotation
//    is granted one cycle later.

Source files
------------

// File: rtl/mm_arb_pkg.sv
// Shared types and width helpers for the round-robin memory-mapped arbiter.
package mm_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int iwidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must reach the value n.
    function automatic int cwidth(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/mm_rr_arbiter_if.sv
// Requester-side and shared-slave-side memory-mapped signals of the arbiter.
interface mm_rr_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 8
);
    logic [NPORTS-1:0][AWIDTH-1:0] s_addr;
    logic [NPORTS-1:0]             s_wreq;
    logic [NPORTS-1:0][DWIDTH-1:0] s_wdat;
    logic [NPORTS-1:0]             s_rreq;
    logic [NPORTS-1:0][DWIDTH-1:0] s_rdat;
    logic [NPORTS-1:0]             s_busy;
    logic [AWIDTH-1:0]             m_addr;
    logic                          m_wreq;
    logic [DWIDTH-1:0]             m_wdat;
    logic                          m_rreq;
    logic [DWIDTH-1:0]             m_rdat;
    logic                          m_busy;

    modport arb (
        input  s_addr, s_wreq, s_wdat, s_rreq, m_rdat, m_busy,
        output s_rdat, s_busy, m_addr, m_wreq, m_wdat, m_rreq
    );

    modport master (
        output s_addr, s_wreq, s_wdat, s_rreq,
        input  s_rdat, s_busy
    );

    modport slave (
        input  m_addr, m_wreq, m_wdat, m_rreq,
        output m_rdat, m_busy
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first active request after last_i, scanning cyclically.
module rr_pick
    import mm_arb_pkg::*;
#(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0]              req_i,
    input  logic [iwidth(NPORTS)-1:0]      last_i,
    output logic [iwidth(NPORTS)-1:0]      idx_o,
    output logic                           found_o
);

    localparam int IW = iwidth(NPORTS);

    always_comb begin
        int cand;
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        // Offset 1 first so the previous grantee has the lowest priority.
        for (int k = 1; k <= NPORTS; k++) begin
            cand = (int'(last_i) + k) % NPORTS;
            if (!found_o && req_i[IW'(cand)]) begin
                found_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mm_rr_arbiter.sv
// Round-robin arbiter sharing one memory-mapped slave among NPORTS masters,
// with a registered grant and an optional burst hold under contention.
module mm_rr_arbiter
    import mm_arb_pkg::*;
#(
    parameter int NPORTS   = 4,
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 8,
    parameter int MAXBURST = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    mm_rr_arbiter_if.arb              bus,
    output logic [iwidth(NPORTS)-1:0] gnt_idx
);

    localparam int IW = iwidth(NPORTS);
    localparam int CW = cwidth(MAXBURST);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] gmask;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic              g_req;
    logic              others;
    logic [AWIDTH-1:0] addr_mux;
    logic [DWIDTH-1:0] wdat_mux;

    assign req = bus.s_wreq | bus.s_rreq;

    rr_pick #(.NPORTS(NPORTS)) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        gmask        = '0;
        gmask[gnt_q] = 1'b1;
    end

    assign g_req  = req[gnt_q];
    assign others = |(req & ~gmask);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!g_req) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end else if (!bus.m_busy) begin
                    cnt_d = (cnt_q == CW'(MAXBURST)) ? cnt_q : cnt_q + 1'b1;
                    // Yield only when someone else is waiting and the burst allowance is spent.
                    if (others && (int'(cnt_q) + 1 >= MAXBURST)) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NPORTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output path is combinational from state so reset quiets the slave immediately.
    always_comb begin
        addr_mux     = '0;
        wdat_mux     = '0;
        bus.m_wreq   = 1'b0;
        bus.m_rreq   = 1'b0;
        bus.s_busy   = '1;
        if (state_q == GRANT) begin
            addr_mux          = bus.s_addr[gnt_q];
            wdat_mux          = bus.s_wdat[gnt_q];
            bus.m_wreq        = bus.s_wreq[gnt_q];
            bus.m_rreq        = bus.s_rreq[gnt_q];
            bus.s_busy[gnt_q] = bus.m_busy;
        end
    end

    assign bus.m_addr = addr_mux;
    assign bus.m_wdat = wdat_mux;
    assign bus.s_rdat = {NPORTS{bus.m_rdat}};
    assign gnt_idx    = gnt_q;

endmodule

// File: tb/tb_mm_rr_arbiter.sv
// Directed bench for mm_rr_arbiter: one instance with MAXBURST=1, one with MAXBURST=4.
module tb_mm_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] gntA;
    logic [1:0] gntB;
    int         total = 0;
    int         bad   = 0;

    mm_rr_arbiter_if #(.NPORTS(4), .AWIDTH(8), .DWIDTH(8)) bA ();
    mm_rr_arbiter_if #(.NPORTS(4), .AWIDTH(8), .DWIDTH(8)) bB ();

    mm_rr_arbiter #(.NPORTS(4), .AWIDTH(8), .DWIDTH(8), .MAXBURST(1)) dutA (
        .clk     (clk),
        .reset   (reset),
        .bus     (bA),
        .gnt_idx (gntA)
    );

    mm_rr_arbiter #(.NPORTS(4), .AWIDTH(8), .DWIDTH(8), .MAXBURST(4)) dutB (
        .clk     (clk),
        .reset   (reset),
        .bus     (bB),
        .gnt_idx (gntB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] eb;
        int         p;
        reset     = 1'b1;
        bA.s_addr = '0; bA.s_wreq = '0; bA.s_wdat = '0; bA.s_rreq = '0;
        bA.m_rdat = '0; bA.m_busy = 1'b0;
        bB.s_addr = '0; bB.s_wreq = '0; bB.s_wdat = '0; bB.s_rreq = '0;
        bB.m_rdat = '0; bB.m_busy = 1'b0;

        // Reset state
        cyc(); #1;
        chk("rst_busy", bA.s_busy, 4'hF);
        chk("rst_wreq", bA.m_wreq, 0);
        chk("rst_rreq", bA.m_rreq, 0);
        chk("rst_addr", bA.m_addr, 0);
        chk("rst_gnt",  gntA, 0);

        // 1: single write from port 1
        cyc();
        reset = 1'b0;
        bA.s_wreq[1] = 1'b1; bA.s_addr[1] = 8'h12; bA.s_wdat[1] = 8'hA5;
        #1;
        chk("t1_idle_busy", bA.s_busy, 4'hF);
        chk("t1_idle_wreq", bA.m_wreq, 0);
        cyc(); #1;
        chk("t1_wreq", bA.m_wreq, 1);
        chk("t1_addr", bA.m_addr, 8'h12);
        chk("t1_wdat", bA.m_wdat, 8'hA5);
        chk("t1_gnt",  gntA, 1);
        chk("t1_busy", bA.s_busy, 4'b1101);
        cyc();
        bA.s_wreq[1] = 1'b0;
        #1;
        chk("t1_drop_wreq", bA.m_wreq, 0);
        cyc(); #1;
        chk("t1_back_idle", bA.s_busy, 4'hF);

        // 2: all ports request, MAXBURST=1
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bA.s_addr[i] = 8'h40 + 8'(i);
            bA.s_wreq[i] = 1'b1;
        end
        #1;
        chk("t2_idle0", bA.s_busy, 4'hF);
        for (int k = 0; k < 5; k++) begin
            p = k % 4;
            eb = 4'hF;
            eb[p] = 1'b0;
            cyc(); #1;
            chk("t2_gnt",  gntA, 32'(p));
            chk("t2_addr", bA.m_addr, 32'h40 + 32'(p));
            chk("t2_busy", bA.s_busy, eb);
            cyc(); #1;
            chk("t2_gap_busy", bA.s_busy, 4'hF);
            chk("t2_gap_wreq", bA.m_wreq, 0);
        end
        bA.s_wreq = '0;

        // 3: MAXBURST=4 streaming, then contention
        bB.s_rreq[2] = 1'b1; bB.s_addr[2] = 8'h20; bB.m_rdat = 8'h55;
        cyc(); #1;
        chk("t3_gnt",  gntB, 2);
        chk("t3_rreq", bB.m_rreq, 1);
        chk("t3_addr", bB.m_addr, 8'h20);
        chk("t3_busy", bB.s_busy, 4'b1011);
        chk("t3_rdat", bB.s_rdat[2], 8'h55);
        for (int j = 1; j < 3; j++) begin
            cyc();
            bB.s_addr[2] = 8'h20 + 8'(j);
            #1;
            chk("t3_stream_gnt",  gntB, 2);
            chk("t3_stream_busy", bB.s_busy, 4'b1011);
            chk("t3_stream_addr", bB.m_addr, 32'h20 + 32'(j));
        end
        cyc();
        bB.s_addr[2] = 8'h23;
        bB.s_rreq[0] = 1'b1; bB.s_addr[0] = 8'h0A;
        #1;
        chk("t3_fourth_gnt",  gntB, 2);
        chk("t3_fourth_busy", bB.s_busy, 4'b1011);
        chk("t3_fourth_addr", bB.m_addr, 8'h23);
        cyc();
        bB.s_rreq[2] = 1'b0;
        #1;
        chk("t3_idle_busy", bB.s_busy, 4'hF);
        chk("t3_idle_rreq", bB.m_rreq, 0);
        cyc(); #1;
        chk("t3_p0_gnt",  gntB, 0);
        chk("t3_p0_addr", bB.m_addr, 8'h0A);
        chk("t3_p0_busy", bB.s_busy, 4'b1110);
        bB.s_rreq[0] = 1'b0;
        cyc();
        cyc();

        // 4: port 3 read stalled by slave busy
        bA.m_busy = 1'b1;
        bA.s_rreq[3] = 1'b1; bA.s_addr[3] = 8'h33;
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_wait_gnt",  gntA, 3);
            chk("t4_wait_rreq", bA.m_rreq, 1);
            chk("t4_wait_busy", bA.s_busy, 4'hF);
            if (i < 4) cyc();
        end
        cyc();
        bA.m_busy = 1'b0; bA.m_rdat = 8'h3C;
        #1;
        chk("t4_done_busy", bA.s_busy, 4'b0111);
        chk("t4_done_rdat", bA.s_rdat[3], 8'h3C);
        chk("t4_done_gnt",  gntA, 3);
        cyc();
        bA.s_rreq[3] = 1'b0;
        cyc(); #1;
        chk("t4_idle_busy", bA.s_busy, 4'hF);

        // 5: reset during an active write
        bA.s_wreq[1] = 1'b1; bA.s_addr[1] = 8'h51; bA.m_busy = 1'b1;
        cyc(); #1;
        chk("t5_pre_wreq", bA.m_wreq, 1);
        chk("t5_pre_gnt",  gntA, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_wreq", bA.m_wreq, 0);
        chk("t5_rst_busy", bA.s_busy, 4'hF);
        chk("t5_rst_gnt",  gntA, 0);
        cyc();
        reset = 1'b0;
        bA.s_wreq = '0;
        bA.s_wreq[0] = 1'b1; bA.s_addr[0] = 8'h50;
        bA.s_wreq[2] = 1'b1; bA.s_addr[2] = 8'h52;
        bA.m_busy = 1'b0;
        #1;
        chk("t5_idle_busy", bA.s_busy, 4'hF);
        cyc(); #1;
        chk("t5_gnt",  gntA, 0);
        chk("t5_addr", bA.m_addr, 8'h50);
        chk("t5_busy", bA.s_busy, 4'b1110);
        bA.s_wreq = '0;
        cyc(); #1;
        chk("t5_end_busy", bA.s_busy, 4'hF);

        // 6: granted port aborts while slave is busy
        bA.m_busy = 1'b1;
        bA.s_wreq[1] = 1'b1; bA.s_addr[1] = 8'h61;
        bA.s_wreq[3] = 1'b1; bA.s_addr[3] = 8'h63;
        cyc(); #1;
        chk("t6_gnt",  gntA, 1);
        chk("t6_wreq", bA.m_wreq, 1);
        chk("t6_addr", bA.m_addr, 8'h61);
        bA.s_wreq[1] = 1'b0;
        #1;
        chk("t6_abort_wreq", bA.m_wreq, 0);
        cyc(); #1;
        chk("t6_idle_busy", bA.s_busy, 4'hF);
        chk("t6_idle_wreq", bA.m_wreq, 0);
        cyc(); #1;
        chk("t6_next_gnt",  gntA, 3);
        chk("t6_next_wreq", bA.m_wreq, 1);
        chk("t6_next_addr", bA.m_addr, 8'h63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
